// File: rtl/terminal_pin_pkg.sv
// Shared definitions for the gate-side keypad/sensor front-end.
package terminal_pin_pkg;

    // The 3-bit encoding is fixed so external checkers can compare states numerically.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D1     = 3'd1,
        D2     = 3'd2,
        ENVIO  = 3'd3,
        ESPERA = 3'd4,
        PASO   = 3'd5,
        BLOQ   = 3'd6
    } state_e;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [1:0] INTENTOS_MAX = 2'd3;

    // Failed-attempt counter increments but never wraps.
    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == INTENTOS_MAX) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/terminal_pin_antirrebote.sv
// Debounce filter: the output follows the input only after DEBOUNCE
// consecutive samples that disagree with the current output.
module antirrebote #(
    parameter int DEBOUNCE = 3
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_i,
    output logic filtered_o
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

    logic       raw_q, raw_d;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    // Count consecutive registered samples that differ from the filtered level.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        raw_d  = raw_i;
        filt_d = filt_q;
        cnt_d  = 4'd0;
        if (raw_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = raw_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Sample register, filtered level and run-length counter.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
        if (!Reset) begin
            raw_q  <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            raw_q  <= raw_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filtered_o = filt_q;

endmodule

// File: rtl/terminal_pin.sv
// Keypad/sensor front-end: debounced arrival, two-digit BCD PIN entry,
// submit/response sequencing, retries, lockout and vehicle passage.
module terminal_pin
    import terminal_pin_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Llegada,
    input  logic       Paso,
    input  logic [3:0] Digito,
    input  logic       DigitoValido,
    input  logic       Borrar,
    input  logic       Abierto,
    input  logic       Cerrado,
    input  logic       Alarma,
    input  logic       Bloqueo,
    output logic       Vehiculo,
    output logic [7:0] Pin,
    output logic       enterPin,
    output logic       Termino,
    output logic       Listo,
    output logic [1:0] Intentos,
    output logic       Error
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] pin_q, pin_d;
    logic [1:0] intentos_q, intentos_d;
    logic [7:0] timer_q, timer_d;
    logic       vehiculo_q, vehiculo_d;
    logic       enter_q, enter_d;
    logic       termino_q, termino_d;
    logic       error_q, error_d;
    logic       llegada_prev_q;
    logic       paso_q;

    logic llegada_deb;
    logic llegada_rise, llegada_fall, paso_rise;
    logic digit_ok, digit_bad;

    // The gate status line carries no decision for this block.
    logic cerrado_unused;
    assign cerrado_unused = Cerrado;

    antirrebote #(.DEBOUNCE(DEBOUNCE)) u_llegada (
        .Clk        (Clk),
        .Reset      (Reset),
        .raw_i      (Llegada),
        .filtered_o (llegada_deb)
    );

    assign llegada_rise = llegada_deb & ~llegada_prev_q;
    assign llegada_fall = ~llegada_deb & llegada_prev_q;
    assign paso_rise    = Paso & ~paso_q;
    assign digit_ok     = DigitoValido && (Digito <= BCD_MAX);
    assign digit_bad    = DigitoValido && (Digito > BCD_MAX);

    // Next-state and registered-output logic for the entry sequence.
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        intentos_d = intentos_q;
        timer_d    = timer_q;
        vehiculo_d = vehiculo_q;
        enter_d    = 1'b0;
        termino_d  = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // Vehiculo lingers one cycle after Termino, then drops here.
                vehiculo_d = 1'b0;
                if (llegada_rise) begin
                    vehiculo_d = 1'b1;
                    pin_d      = 8'h00;
                    state_d    = D1;
                end
            end
            D1, D2: begin
                if (llegada_fall) begin
                    vehiculo_d = 1'b0;
                    pin_d      = 8'h00;
                    intentos_d = 2'd0;
                    state_d    = IDLE;
                end else if (Borrar) begin
                    pin_d   = 8'h00;
                    state_d = D1;
                end else if (digit_ok) begin
                    if (state_q == D1) begin
                        pin_d[7:4] = Digito;
                        state_d    = D2;
                    end else begin
                        pin_d[3:0] = Digito;
                        enter_d    = 1'b1;
                        state_d    = ENVIO;
                    end
                end else if (digit_bad) begin
                    error_d = 1'b1;
                end
            end
            ENVIO: begin
                timer_d = 8'd0;
                state_d = ESPERA;
            end
            ESPERA: begin
                // A response on the final count still beats the timeout.
                if (Bloqueo) begin
                    state_d = BLOQ;
                end else if (Alarma) begin
                    intentos_d = sat_inc(intentos_q);
                    pin_d      = 8'h00;
                    state_d    = D1;
                end else if (Abierto) begin
                    state_d = PASO;
                end else if (timer_q == TIMER_LAST) begin
                    error_d = 1'b1;
                    pin_d   = 8'h00;
                    state_d = D1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            PASO: begin
                if (paso_rise) begin
                    termino_d  = 1'b1;
                    intentos_d = 2'd0;
                    state_d    = IDLE;
                end
            end
            BLOQ: begin
                if (!Bloqueo) begin
                    intentos_d = 2'd0;
                    pin_d      = 8'h00;
                    state_d    = D1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, data and strobe registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q        <= IDLE;
            pin_q          <= 8'h00;
            intentos_q     <= 2'd0;
            timer_q        <= 8'd0;
            vehiculo_q     <= 1'b0;
            enter_q        <= 1'b0;
            termino_q      <= 1'b0;
            error_q        <= 1'b0;
            llegada_prev_q <= 1'b0;
            paso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pin_q          <= pin_d;
            intentos_q     <= intentos_d;
            timer_q        <= timer_d;
            vehiculo_q     <= vehiculo_d;
            enter_q        <= enter_d;
            termino_q      <= termino_d;
            error_q        <= error_d;
            llegada_prev_q <= llegada_deb;
            paso_q         <= Paso;
        end
    end

    assign Vehiculo = vehiculo_q;
    assign Pin      = pin_q;
    assign enterPin = enter_q;
    assign Termino  = termino_q;
    assign Intentos = intentos_q;
    assign Error    = error_q;
    assign Listo    = (state_q == D1) || (state_q == D2);

endmodule

// File: tb/tb_terminal_pin.sv
// Directed bench for terminal_pin: a vector table for arrival, entry,
// passage and invalid-digit handling, then hand sequences for retries,
// lockout, timeout, debounce/abort and mid-operation reset.
module tb_terminal_pin;
    import terminal_pin_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       llegada, paso, dv, borrar, abierto, cerrado, alarma, bloqueo;
    logic [3:0] digito;
    logic       vehiculo, enter_pin, termino, listo, error;
    logic [7:0] pin;
    logic [1:0] intentos;

    int checks = 0;
    int errors = 0;

    terminal_pin #(.DEBOUNCE(3), .TIMEOUT(4)) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .Llegada      (llegada),
        .Paso         (paso),
        .Digito       (digito),
        .DigitoValido (dv),
        .Borrar       (borrar),
        .Abierto      (abierto),
        .Cerrado      (cerrado),
        .Alarma       (alarma),
        .Bloqueo      (bloqueo),
        .Vehiculo     (vehiculo),
        .Pin          (pin),
        .enterPin     (enter_pin),
        .Termino      (termino),
        .Listo        (listo),
        .Intentos     (intentos),
        .Error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ll, pa;
        logic [3:0] dig;
        logic       dv, bo, ab, al, bl;
        logic       veh;
        logic [7:0] pin;
        logic       en, te, li;
        logic [1:0] in;
        logic       er;
        state_e     st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ll, pa, input logic [3:0] dig,
                                input logic dv_i, bo, ab, al, bl,
                                input logic veh, input logic [7:0] p,
                                input logic en, te, li, input logic [1:0] in,
                                input logic er, input state_e st);
        vec_t v;
        v.ll = ll; v.pa = pa; v.dig = dig; v.dv = dv_i; v.bo = bo;
        v.ab = ab; v.al = al; v.bl = bl; v.veh = veh; v.pin = p;
        v.en = en; v.te = te; v.li = li; v.in = in; v.er = er; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic veh, input logic [7:0] p,
                              input logic en, te, li, input logic [1:0] in,
                              input logic er, input state_e st);
        check({tag, ".vehiculo"}, 32'(vehiculo), 32'(veh));
        check({tag, ".pin"},      32'(pin),      32'(p));
        check({tag, ".enterPin"}, 32'(enter_pin), 32'(en));
        check({tag, ".termino"},  32'(termino),  32'(te));
        check({tag, ".listo"},    32'(listo),    32'(li));
        check({tag, ".intentos"}, 32'(intentos), 32'(in));
        check({tag, ".error"},    32'(error),    32'(er));
        check({tag, ".state"},    32'(dut.state_q), 32'(st));
    endtask

    task automatic clear_keys();
        paso = 0; digito = 4'd0; dv = 0; borrar = 0;
        abierto = 0; cerrado = 0; alarma = 0; bloqueo = 0;
    endtask

    // Enter two digits from D1 and follow the design into ESPERA.
    task automatic submit(input string tag, input logic [3:0] a, input logic [3:0] b);
        digito = a; dv = 1; tick();
        digito = b; tick();
        dv = 0;
        check({tag, ".enter"}, 32'(enter_pin), 32'd1);
        check({tag, ".envio"}, 32'(dut.state_q), 32'(ENVIO));
        check({tag, ".pin"},   32'(pin), 32'({a, b}));
        tick();
        check({tag, ".espera"}, 32'(dut.state_q), 32'(ESPERA));
        check({tag, ".enter_low"}, 32'(enter_pin), 32'd0);
    endtask

    initial begin
        logic [1:0] exp_int;

        rst_n = 0; llegada = 0; clear_keys();
        tick(); tick();
        expect_out("reset", 0, 8'h00, 0, 0, 0, 2'd0, 0, IDLE);
        check("reset.deb_cnt", 32'(dut.u_llegada.cnt_q), 32'd0);
        rst_n = 1;

        // Arrival, entry 1-2, Abierto, passage, departure, second arrival, bad digit, clear.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 0,8'h00,0,0,0,2'd0,0,IDLE));
        vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 1,8'h00,0,0,1,2'd0,0,D1));
        vecs.push_back(mk(1,0,4'd1,1,0,0,0,0, 1,8'h10,0,0,1,2'd0,0,D2));
        vecs.push_back(mk(1,0,4'd2,1,0,0,0,0, 1,8'h12,1,0,0,2'd0,0,ENVIO));
        vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 1,8'h12,0,0,0,2'd0,0,ESPERA));
        vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 1,8'h12,0,0,0,2'd0,0,ESPERA));
        vecs.push_back(mk(1,0,4'd0,0,0,1,0,0, 1,8'h12,0,0,0,2'd0,0,PASO));
        vecs.push_back(mk(1,1,4'd0,0,0,0,0,0, 1,8'h12,0,1,0,2'd0,0,IDLE));
        vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 0,8'h12,0,0,0,2'd0,0,IDLE));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,4'd0,0,0,0,0,0, 0,8'h12,0,0,0,2'd0,0,IDLE));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 0,8'h12,0,0,0,2'd0,0,IDLE));
        vecs.push_back(mk(1,0,4'd0,0,0,0,0,0, 1,8'h00,0,0,1,2'd0,0,D1));
        vecs.push_back(mk(1,0,4'hA,1,0,0,0,0, 1,8'h00,0,0,1,2'd0,1,D1));
        vecs.push_back(mk(1,0,4'd7,1,0,0,0,0, 1,8'h70,0,0,1,2'd0,0,D2));
        vecs.push_back(mk(1,0,4'd3,1,1,0,0,0, 1,8'h00,0,0,1,2'd0,0,D1));

        foreach (vecs[i]) begin
            llegada = vecs[i].ll; paso = vecs[i].pa; digito = vecs[i].dig;
            dv = vecs[i].dv; borrar = vecs[i].bo; abierto = vecs[i].ab;
            alarma = vecs[i].al; bloqueo = vecs[i].bl;
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].veh, vecs[i].pin, vecs[i].en,
                       vecs[i].te, vecs[i].li, vecs[i].in, vecs[i].er, vecs[i].st);
        end
        clear_keys();

        // Four Alarma answers: attempts count up and saturate at 3.
        for (int i = 1; i <= 4; i++) begin
            submit($sformatf("wrong%0d", i), 4'd1, 4'd3);
            alarma = 1; tick(); alarma = 0;
            exp_int = (i > 3) ? 2'd3 : 2'(i);
            expect_out($sformatf("alarma%0d", i), 1, 8'h00, 0, 0, 1, exp_int, 0, D1);
        end
        submit("lock", 4'd5, 4'd6);
        bloqueo = 1; tick();
        expect_out("bloq", 1, 8'h56, 0, 0, 0, 2'd3, 0, BLOQ);
        digito = 4'd2; dv = 1; tick(); dv = 0;
        expect_out("bloq_key", 1, 8'h56, 0, 0, 0, 2'd3, 0, BLOQ);
        bloqueo = 0; tick();
        expect_out("unlock", 1, 8'h00, 0, 0, 1, 2'd0, 0, D1);

        // Timeout after exactly four ESPERA cycles; Cerrado has no effect.
        submit("pre_to", 4'd4, 4'd4);
        alarma = 1; tick(); alarma = 0;
        check("pre_to.intentos", 32'(intentos), 32'd1);
        submit("to", 4'd7, 4'd7);
        cerrado = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("to.wait%0d", k), 32'(dut.state_q), 32'(ESPERA));
            check($sformatf("to.noerr%0d", k), 32'(error), 32'd0);
        end
        cerrado = 0;
        tick();
        expect_out("timeout", 1, 8'h00, 0, 0, 1, 2'd1, 1, D1);

        // A response on the last count wins over the timeout.
        submit("edge", 4'd2, 4'd2);
        repeat (3) tick();
        alarma = 1; tick(); alarma = 0;
        expect_out("edge_alarma", 1, 8'h00, 0, 0, 1, 2'd2, 0, D1);

        // Abort: one digit, then Llegada low long enough to be accepted.
        digito = 4'd4; dv = 1; tick(); dv = 0;
        expect_out("abort_digit", 1, 8'h40, 0, 0, 1, 2'd2, 0, D2);
        llegada = 0;
        repeat (4) tick();
        check("abort.hold", 32'(dut.state_q), 32'(D2));
        tick();
        expect_out("abort", 0, 8'h00, 0, 0, 0, 2'd0, 0, IDLE);

        // Two-cycle glitch is filtered out.
        llegada = 1; tick(); tick(); llegada = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("glitch.veh%0d", k), 32'(vehiculo), 32'd0);
            check($sformatf("glitch.st%0d", k), 32'(dut.state_q), 32'(IDLE));
        end

        // Reset while enterPin is high drops the strobe and everything else.
        llegada = 1;
        repeat (5) tick();
        check("rst_arr.state", 32'(dut.state_q), 32'(D1));
        digito = 4'd9; dv = 1; tick();
        digito = 4'd8; tick(); dv = 0;
        expect_out("pre_rst", 1, 8'h98, 1, 0, 0, 2'd0, 0, ENVIO);
        rst_n = 0; tick();
        expect_out("mid_rst", 0, 8'h00, 0, 0, 0, 2'd0, 0, IDLE);
        check("mid_rst.deb_cnt", 32'(dut.u_llegada.cnt_q), 32'd0);
        rst_n = 1; llegada = 0; tick();
        expect_out("post_rst", 0, 8'h00, 0, 0, 0, 2'd0, 0, IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
